// File: rtl/btn_uart_cmd_arbiter_pkg.sv
// Shared command codes, ASCII constants, FSM encodings and the UART byte decoder
// for the button/UART command arbiter.
package btn_uart_cmd_arbiter_pkg;

  localparam logic [2:0] CMD_L    = 3'd0;
  localparam logic [2:0] CMD_R    = 3'd1;
  localparam logic [2:0] CMD_C    = 3'd2;
  localparam logic [2:0] CMD_MODE = 3'd3;
  localparam logic [2:0] CMD_UD   = 3'd4;

  localparam logic [7:0] ASCII_L_UP = 8'h4C;
  localparam logic [7:0] ASCII_L_LO = 8'h6C;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_M_UP = 8'h4D;
  localparam logic [7:0] ASCII_M_LO = 8'h6D;
  localparam logic [7:0] ASCII_U_UP = 8'h55;
  localparam logic [7:0] ASCII_U_LO = 8'h75;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // valid: byte maps to a command; ignore: line terminator, silently dropped
  typedef struct packed {
    logic       valid;
    logic       ignore;
    logic [2:0] cmd;
  } dec_t;

  function automatic dec_t decode_byte(input logic [7:0] b);
    dec_t d;
    d.valid  = 1'b1;
    d.ignore = 1'b0;
    d.cmd    = CMD_L;
    case (b)
      ASCII_L_UP, ASCII_L_LO: d.cmd = CMD_L;
      ASCII_R_UP, ASCII_R_LO: d.cmd = CMD_R;
      ASCII_C_UP, ASCII_C_LO: d.cmd = CMD_C;
      ASCII_M_UP, ASCII_M_LO: d.cmd = CMD_MODE;
      ASCII_U_UP, ASCII_U_LO: d.cmd = CMD_UD;
      ASCII_CR, ASCII_LF: begin
        d.valid  = 1'b0;
        d.ignore = 1'b1;
      end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_uart_cmd_arbiter_cmd_fifo.sv
// Small synchronous FIFO holding decoded UART commands. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module btn_uart_cmd_arbiter_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_din,
  output logic [WIDTH-1:0]  o_dout,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/btn_uart_cmd_arbiter.sv
// Merges edge-detected button pulses and UART ASCII commands into a single paced
// stream of one-cycle button pulses plus mode/up-down switch overrides. Physical
// buttons always win over queued UART commands.
module btn_uart_cmd_arbiter
  import btn_uart_cmd_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_btn_L,
  input  logic              i_btn_R,
  input  logic              i_btn_C,
  input  logic              i_sw_watch_stopwatch,
  input  logic              i_sw_up_down,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic              o_btn_L,
  output logic              o_btn_R,
  output logic              o_btn_C,
  output logic              o_sw_watch_stopwatch,
  output logic              o_sw_up_down,
  output logic [ADDR_W:0]   o_fifo_count,
  output logic              o_drop,
  output logic              o_cmd_err,
  output logic              o_busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [2:0]       r_cmd;
  logic             r_p_L;
  logic             r_p_R;
  logic             r_p_C;
  logic             r_mode_tgl;
  logic             r_ud_tgl;
  logic             r_drop;
  logic             r_cmd_err;

  dec_t             w_dec;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [2:0]       w_fifo_dout;
  logic             w_clr_L;
  logic             w_clr_R;
  logic             w_clr_C;
  logic             w_load;
  logic [2:0]       w_load_cmd;

  assign w_dec  = decode_byte(i_rx_data);
  assign w_push = i_rx_done & w_dec.valid;

  btn_uart_cmd_arbiter_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (3)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_dec.cmd),
    .o_dout  (w_fifo_dout),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky pending flags: a new pulse re-arms even in the cycle its flag is consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_L <= 1'b0;
      r_p_R <= 1'b0;
      r_p_C <= 1'b0;
    end else begin
      r_p_L <= (r_p_L & ~w_clr_L) | i_btn_L;
      r_p_R <= (r_p_R & ~w_clr_R) | i_btn_R;
      r_p_C <= (r_p_C & ~w_clr_C) | i_btn_C;
    end
  end

  // Next-state logic: physical C>L>R first, then the UART queue
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clr_L     = 1'b0;
    w_clr_R     = 1'b0;
    w_clr_C     = 1'b0;
    w_load      = 1'b0;
    w_load_cmd  = CMD_L;
    case (r_state)
      ST_IDLE: begin
        if (r_p_C) begin
          w_clr_C     = 1'b1;
          w_load      = 1'b1;
          w_load_cmd  = CMD_C;
          w_state_nxt = ST_ISSUE;
        end else if (r_p_L) begin
          w_clr_L     = 1'b1;
          w_load      = 1'b1;
          w_load_cmd  = CMD_L;
          w_state_nxt = ST_ISSUE;
        end else if (r_p_R) begin
          w_clr_R     = 1'b1;
          w_load      = 1'b1;
          w_load_cmd  = CMD_R;
          w_state_nxt = ST_ISSUE;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_load_cmd  = w_fifo_dout;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register and gap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ISSUE)    r_gap_cnt <= '0;
      else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  // Command being issued; only meaningful while in ISSUE so it carries no reset
  always_ff @(posedge clk) begin
    if (w_load) r_cmd <= w_load_cmd;
  end

  // Switch override toggles flip at the end of the ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_tgl <= 1'b0;
      r_ud_tgl   <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      if (r_cmd == CMD_MODE) r_mode_tgl <= ~r_mode_tgl;
      if (r_cmd == CMD_UD)   r_ud_tgl   <= ~r_ud_tgl;
    end
  end

  // Registered one-cycle status pulses for lost and unrecognised bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_drop    <= w_push & w_full & ~w_pop;
      r_cmd_err <= i_rx_done & ~w_dec.valid & ~w_dec.ignore;
    end
  end

  assign o_btn_L              = (r_state == ST_ISSUE) && (r_cmd == CMD_L);
  assign o_btn_R              = (r_state == ST_ISSUE) && (r_cmd == CMD_R);
  assign o_btn_C              = (r_state == ST_ISSUE) && (r_cmd == CMD_C);
  assign o_sw_watch_stopwatch = i_sw_watch_stopwatch ^ r_mode_tgl;
  assign o_sw_up_down         = i_sw_up_down ^ r_ud_tgl;
  assign o_drop               = r_drop;
  assign o_cmd_err            = r_cmd_err;
  assign o_busy               = (r_state != ST_IDLE);

endmodule

// File: tb/tb_btn_uart_cmd_arbiter.sv
// Directed bench for btn_uart_cmd_arbiter: per-cycle vector table plus
// hand-written multi-cycle sequences for ordering, overflow and reset.
module tb_btn_uart_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_btn_L, i_btn_R, i_btn_C;
  logic       i_sw_watch_stopwatch, i_sw_up_down;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       o_btn_L, o_btn_R, o_btn_C;
  logic       o_sw_watch_stopwatch, o_sw_up_down;
  logic [2:0] o_fifo_count;
  logic       o_drop, o_cmd_err, o_busy;

  always #5 clk = ~clk;

  btn_uart_cmd_arbiter #(
    .GAP_CYCLES (4),
    .FIFO_DEPTH (4),
    .ADDR_W     (2)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_btn_L              (i_btn_L),
    .i_btn_R              (i_btn_R),
    .i_btn_C              (i_btn_C),
    .i_sw_watch_stopwatch (i_sw_watch_stopwatch),
    .i_sw_up_down         (i_sw_up_down),
    .i_rx_data            (i_rx_data),
    .i_rx_done            (i_rx_done),
    .o_btn_L              (o_btn_L),
    .o_btn_R              (o_btn_R),
    .o_btn_C              (o_btn_C),
    .o_sw_watch_stopwatch (o_sw_watch_stopwatch),
    .o_sw_up_down         (o_sw_up_down),
    .o_fifo_count         (o_fifo_count),
    .o_drop               (o_drop),
    .o_cmd_err            (o_cmd_err),
    .o_busy               (o_busy)
  );

  // observed vector: {btnL,btnR,btnC, busy, drop, err, count[2:0], sw_ws, sw_ud}
  logic [10:0] w_obs;
  assign w_obs = {o_btn_L, o_btn_R, o_btn_C, o_busy, o_drop, o_cmd_err,
                  o_fifo_count, o_sw_watch_stopwatch, o_sw_up_down};

  typedef struct {
    logic [2:0]  b;
    logic        rd;
    logic [7:0]  rx;
    logic        sws;
    logic        ud;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  logic t_sws = 1'b0, t_ud = 1'b0, e_sws = 1'b0, e_ud = 1'b0;

  logic [2:0] btn_hist [48];
  logic       drop_hist [48];
  logic [2:0] cnt_hist [48];
  logic [2:0] eb;
  logic [2:0] ecnt;
  logic       edrop;
  logic [7:0] bytes [7];

  task automatic add(input logic [2:0] b, input logic rd, input logic [7:0] rx,
                     input logic [2:0] xb, input logic xbusy, input logic xerr,
                     input logic [2:0] xcnt);
    vec_t v;
    v.b   = b;
    v.rd  = rd;
    v.rx  = rx;
    v.sws = t_sws;
    v.ud  = t_ud;
    v.exp = {xb, xbusy, 1'b0, xerr, xcnt, e_sws, e_ud};
    tbl.push_back(v);
  endtask

  task automatic idle(input int n, input logic xbusy);
    for (int i = 0; i < n; i++) add(3'b000, 1'b0, 8'h00, 3'b000, xbusy, 1'b0, 3'd0);
  endtask

  // Drive one cycle's inputs at the falling edge and let outputs settle
  task automatic step(input logic [2:0] b, input logic rd, input logic [7:0] rx);
    @(negedge clk);
    {i_btn_L, i_btn_R, i_btn_C} = b;
    i_rx_done = rd;
    i_rx_data = rx;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_btn_L = 0; i_btn_R = 0; i_btn_C = 0;
    i_sw_watch_stopwatch = 0; i_sw_up_down = 0;
    i_rx_data = 8'h00; i_rx_done = 0;

    // ---------------- vector table ----------------
    // test 1: button C, idle -> pulse two cycles later
    add(3'b001, 0, 8'h00, 3'b000, 0, 0, 0);
    idle(1, 0);
    add(3'b000, 0, 8'h00, 3'b001, 1, 0, 0);
    idle(4, 1);
    idle(1, 0);
    // test 2: L and R together -> L first, R one issue period later
    add(3'b110, 0, 8'h00, 3'b000, 0, 0, 0);
    idle(1, 0);
    add(3'b000, 0, 8'h00, 3'b100, 1, 0, 0);
    idle(4, 1);
    idle(1, 0);
    add(3'b000, 0, 8'h00, 3'b010, 1, 0, 0);
    idle(4, 1);
    idle(1, 0);
    // test 5: "M" flips mode override after the ISSUE cycle
    add(3'b000, 1, "M", 3'b000, 0, 0, 0);
    add(3'b000, 0, 8'h00, 3'b000, 0, 0, 1);
    add(3'b000, 0, 8'h00, 3'b000, 1, 0, 0);
    e_sws = 1'b1;
    idle(4, 1);
    idle(1, 0);
    // "u" with physical up/down high -> override returns it to 0
    t_ud = 1'b1; e_ud = 1'b1;
    add(3'b000, 1, "u", 3'b000, 0, 0, 0);
    add(3'b000, 0, 8'h00, 3'b000, 0, 0, 1);
    add(3'b000, 0, 8'h00, 3'b000, 1, 0, 0);
    e_ud = 1'b0;
    idle(4, 1);
    idle(1, 0);
    // "m" again restores mode
    add(3'b000, 1, "m", 3'b000, 0, 0, 0);
    add(3'b000, 0, 8'h00, 3'b000, 0, 0, 1);
    add(3'b000, 0, 8'h00, 3'b000, 1, 0, 0);
    e_sws = 1'b0;
    idle(4, 1);
    idle(1, 0);
    // bad byte -> error pulse; CR -> silent
    add(3'b000, 1, "x", 3'b000, 0, 0, 0);
    add(3'b000, 0, 8'h00, 3'b000, 0, 1, 0);
    add(3'b000, 1, 8'h0D, 3'b000, 0, 0, 0);
    add(3'b000, 0, 8'h00, 3'b000, 0, 0, 0);
    idle(1, 0);
    // UART "c" with empty FIFO -> pulse at t+2
    add(3'b000, 1, "c", 3'b000, 0, 0, 0);
    add(3'b000, 0, 8'h00, 3'b000, 0, 0, 1);
    add(3'b000, 0, 8'h00, 3'b001, 1, 0, 0);
    idle(4, 1);
    idle(1, 0);

    // ---------------- reset state ----------------
    step(3'b000, 0, 8'h00);
    step(3'b000, 0, 8'h00);
    check("reset_state", w_obs, 11'd0);
    reset = 1'b0;

    // ---------------- apply table ----------------
    for (int k = 0; k < tbl.size(); k++) begin
      i_sw_watch_stopwatch = tbl[k].sws;
      i_sw_up_down         = tbl[k].ud;
      step(tbl[k].b, tbl[k].rd, tbl[k].rx);
      check($sformatf("vec%0d", k), w_obs, tbl[k].exp);
    end

    // ---------------- test 3: L pending, then UART R, C ----------------
    for (int c = 0; c < 24; c++) begin
      step((c == 0) ? 3'b100 : 3'b000, (c <= 1), (c == 0) ? 8'h52 : (c == 1) ? 8'h43 : 8'h00);
      btn_hist[c] = {o_btn_L, o_btn_R, o_btn_C};
    end
    for (int c = 0; c < 24; c++) begin
      eb = (c == 2) ? 3'b100 : (c == 8) ? 3'b010 : (c == 14) ? 3'b001 : 3'b000;
      check($sformatf("order_c%0d", c), btn_hist[c], eb);
    end

    // ---------------- test 4: overflow, drops, simultaneous push/pop ----------------
    bytes[0] = "l"; bytes[1] = "R"; bytes[2] = "L"; bytes[3] = "r";
    bytes[4] = "C"; bytes[5] = "c"; bytes[6] = "C";
    for (int c = 0; c < 40; c++) begin
      step((c == 0) ? 3'b001 : 3'b000, (c >= 1 && c <= 7),
           (c >= 1 && c <= 7) ? bytes[(c >= 1 && c <= 7) ? c - 1 : 0] : 8'h00);
      btn_hist[c]  = {o_btn_L, o_btn_R, o_btn_C};
      drop_hist[c] = o_drop;
      cnt_hist[c]  = o_fifo_count;
    end
    for (int c = 0; c < 40; c++) begin
      eb = (c == 2) ? 3'b001 : (c == 8) ? 3'b100 : (c == 14) ? 3'b010 :
           (c == 20) ? 3'b100 : (c == 26) ? 3'b010 : (c == 32) ? 3'b001 : 3'b000;
      edrop = (c == 6 || c == 7);
      if      (c <= 1)  ecnt = 3'd0;
      else if (c <= 4)  ecnt = 3'(c - 1);
      else if (c <= 13) ecnt = 3'd4;
      else if (c <= 19) ecnt = 3'd3;
      else if (c <= 25) ecnt = 3'd2;
      else if (c <= 31) ecnt = 3'd1;
      else              ecnt = 3'd0;
      check($sformatf("ovf_btn_c%0d", c), btn_hist[c], eb);
      check($sformatf("ovf_drop_c%0d", c), drop_hist[c], edrop);
      check($sformatf("ovf_cnt_c%0d", c), cnt_hist[c], ecnt);
    end

    // ---------------- test 6: reset during GAP with 3 queued ----------------
    // up/down toggle is currently set (physical 1 -> output 0)
    step(3'b001, 0, 8'h00);
    step(3'b000, 1, "L");
    step(3'b000, 1, "R");
    step(3'b000, 1, "L");
    step(3'b000, 0, 8'h00);
    check("pre_rst_cnt", o_fifo_count, 3'd3);
    check("pre_rst_busy", o_busy, 1'b1);
    check("pre_rst_ud", o_sw_up_down, 1'b0);
    reset = 1'b1;
    step(3'b000, 0, 8'h00);
    reset = 1'b0;
    check("post_rst_cnt", o_fifo_count, 3'd0);
    check("post_rst_busy", o_busy, 1'b0);
    check("post_rst_ud", o_sw_up_down, 1'b1);
    check("post_rst_ws", o_sw_watch_stopwatch, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step(3'b000, 0, 8'h00);
      check($sformatf("post_rst_quiet_c%0d", c), {o_btn_L, o_btn_R, o_btn_C, o_busy}, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
